// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between the
// instruction-fetch (I) and data (D) ports; one outstanding access at a time.
module unified_mem_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_flush,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic {IDLE, BUSY} state_e;
    typedef enum logic {REQ_I, REQ_D} req_e;

    state_e        state_q, state_d;
    req_e          owner_q, owner_d;
    req_e          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          kill_q, kill_d;
    logic          we_q, we_d;
    logic          win_d;

    assign busy = (state_q == BUSY);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        kill_d   = kill_q;
        we_d     = we_q;
        win_d    = 1'b0;
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        i_rvalid = 1'b0;
        i_rdata  = '0;
        d_rvalid = 1'b0;
        d_rdata  = '0;
        m_en     = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        case (state_q)
            IDLE: begin
                // Grants are withheld while rst is high: the edge would discard them.
                if (!rst && (i_req || d_req)) begin
                    win_d   = d_req && (!i_req || last_q == REQ_I);
                    m_en    = 1'b1;
                    if (win_d) begin
                        d_gnt   = 1'b1;
                        m_we    = d_we;
                        m_addr  = d_addr;
                        m_wdata = d_wdata;
                    end else begin
                        i_gnt   = 1'b1;
                        m_addr  = i_addr;
                    end
                    owner_d = win_d ? REQ_D : REQ_I;
                    last_d  = win_d ? REQ_D : REQ_I;
                    cnt_d   = CW'(MEM_LAT);
                    kill_d  = 1'b0;
                    we_d    = win_d && d_we;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (owner_q == REQ_I && i_flush) begin
                    kill_d = 1'b1;
                end
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    // A flush in the response cycle itself must also suppress it.
                    if (!rst) begin
                        if (owner_q == REQ_I) begin
                            if (!(kill_q || i_flush)) begin
                                i_rvalid = 1'b1;
                                i_rdata  = m_rdata;
                            end
                        end else begin
                            d_rvalid = 1'b1;
                            d_rdata  = we_q ? '0 : m_rdata;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= REQ_I;
            last_q  <= REQ_I;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
            we_q    <= we_d;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench: a cycle-level arbitration model predicts grants and pushes
// expected responses; a separate monitor pops and compares them.
module tb_unified_mem_arbiter;

    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // main instance (MEM_LAT=2)
    logic        rst, i_req, i_flush, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_we, busy;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;

    unified_mem_arbiter #(.MEM_LAT(LAT), .AW(32), .DW(32)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    // second instance (MEM_LAT=1), fetch-only back-to-back
    logic        rst1, i_req1, i_flush1, d_req1, d_we1;
    logic [31:0] i_addr1, d_addr1, d_wdata1, m_rdata1;
    logic        i_gnt1, i_rvalid1, d_gnt1, d_rvalid1, m_en1, m_we1, busy1;
    logic [31:0] i_rdata1, d_rdata1, m_addr1, m_wdata1;
    bit          done1 = 1'b0;

    unified_mem_arbiter #(.MEM_LAT(1), .AW(32), .DW(32)) u_dut1 (
        .clk(clk), .rst(rst1),
        .i_req(i_req1), .i_addr(i_addr1), .i_flush(i_flush1), .i_gnt(i_gnt1),
        .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1),
        .m_rdata(m_rdata1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int idx);
        return (idx == 4) ? 32'h00500093 : 32'hA5000000 + idx * 32'h00010203;
    endfunction

    // memory macro: fixed latency, returns garbage when no read is due
    bit [31:0] mem [64];
    bit        mem_w [64];
    bit [31:0] pipe_d [LAT];
    bit        pipe_v [LAT];
    bit [31:0] garbage;

    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) begin
            pipe_d[k] <= pipe_d[k-1];
            pipe_v[k] <= pipe_v[k-1];
        end
        pipe_v[0] <= m_en;
        pipe_d[0] <= mem_w[m_addr[7:2]] ? mem[m_addr[7:2]] : init_val(int'(m_addr[7:2]));
        if (m_en && m_we) begin
            mem[m_addr[7:2]]   <= m_wdata;
            mem_w[m_addr[7:2]] <= 1'b1;
        end
        garbage <= $urandom;
    end
    assign m_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : garbage;

    // reference model + scoreboard queue
    typedef struct {
        bit          is_d;
        logic [31:0] data;
        int          due;
        bit          killed;
    } exp_t;
    exp_t q[$];
    logic [31:0] shadow [int];
    int free_at = 0;
    bit last_d  = 1'b0;

    always @(negedge clk) begin : predictor
        bit   busy_e, wi, wd;
        int   idx;
        exp_t e;
        if (cyc >= 1) begin
            busy_e = (cyc < free_at);
            wi = 1'b0;
            wd = 1'b0;
            if (!rst && !busy_e) begin
                if (d_req && (!i_req || !last_d)) wd = 1'b1;
                else if (i_req) wi = 1'b1;
            end
            chk("busy", busy, busy_e);
            chk("i_gnt", i_gnt, wi);
            chk("d_gnt", d_gnt, wd);
            chk("m_en", m_en, wi | wd);
            chk("m_we", m_we, wd & d_we);
            chk("m_addr", m_addr, wd ? d_addr : (wi ? i_addr : 32'h0));
            chk("m_wdata", m_wdata, wd ? d_wdata : 32'h0);
            if (busy_e && !rst && i_flush && q.size() > 0 && !q[0].is_d) q[0].killed = 1'b1;
            if (wi || wd) begin
                e.is_d   = wd;
                e.due    = cyc + LAT;
                e.killed = 1'b0;
                idx      = wd ? int'(d_addr[7:2]) : int'(i_addr[7:2]);
                if (wd && d_we) begin
                    shadow[idx] = d_wdata;
                    e.data      = 32'h0;
                end else begin
                    e.data = shadow.exists(idx) ? shadow[idx] : init_val(idx);
                end
                q.push_back(e);
                free_at = cyc + LAT + 1;
                last_d  = wd;
            end
            if (rst) begin
                q.delete();
                free_at = cyc + 1;
                last_d  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (cyc >= 1) begin
            #2;
            if (!i_rvalid) chk("i_rdata_idle", i_rdata, 32'h0);
            if (!d_rvalid) chk("d_rdata_idle", d_rdata, 32'h0);
            if (i_rvalid || d_rvalid) begin
                chk("rvalid_exclusive", i_rvalid & d_rvalid, 1'b0);
                if (q.size() == 0) begin
                    chk("unexpected_rvalid", {i_rvalid, d_rvalid}, 2'b00);
                end else begin
                    e = q.pop_front();
                    chk("rsp_port", d_rvalid, e.is_d);
                    chk("rsp_cycle", cyc, e.due);
                    chk("rsp_not_killed", e.killed, 1'b0);
                    chk("rsp_data", e.is_d ? d_rdata : i_rdata, e.data);
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                if (!e.killed) chk("rsp_missing", 1'b0, 1'b1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input bit want_d, input int budget);
        bit got;
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            got = want_d ? d_gnt : i_gnt;
            step();
        end
        if (!got) chk("gnt_timeout", 1'b0, 1'b1);
    endtask

    initial begin : driver
        bit gi, gd;
        rst = 1'b1; i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // tie from reset: D, I, D
        i_req = 1'b1; i_addr = 32'h20; d_req = 1'b1; d_addr = 32'h24;
        repeat (9) step();
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) step();

        i_req = 1'b1; i_addr = 32'h10;
        wait_gnt(1'b0, 10);
        i_req = 1'b0;
        repeat (4) step();

        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        wait_gnt(1'b1, 10);
        d_we = 1'b0;
        wait_gnt(1'b1, 10);
        d_req = 1'b0;
        repeat (4) step();

        // flush the fetch one cycle after its grant, D pending behind it
        i_req = 1'b1; i_addr = 32'h14;
        wait_gnt(1'b0, 10);
        i_req = 1'b0; i_flush = 1'b1; d_req = 1'b1; d_addr = 32'h40;
        step();
        i_flush = 1'b0;
        wait_gnt(1'b1, 10);
        d_req = 1'b0;
        repeat (4) step();

        // reset in the cycle after a D grant, then a tie
        d_req = 1'b1; d_addr = 32'h44;
        wait_gnt(1'b1, 10);
        d_req = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        i_req = 1'b1; i_addr = 32'h18; d_req = 1'b1; d_addr = 32'h48;
        wait_gnt(1'b1, 10);
        d_req = 1'b0;
        wait_gnt(1'b0, 10);
        i_req = 1'b0;
        repeat (4) step();

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            gi = i_gnt;
            gd = d_gnt;
            step();
            if (i_req && gi) i_req = $urandom_range(0, 1) == 0;
            else if (i_req) i_req = $urandom_range(0, 15) != 0;
            else i_req = $urandom_range(0, 2) == 0;
            if (!i_req || gi) i_addr = 32'($urandom_range(0, 63)) << 2;
            if (d_req && gd) d_req = $urandom_range(0, 1) == 0;
            else if (d_req) d_req = $urandom_range(0, 15) != 0;
            else d_req = $urandom_range(0, 2) == 0;
            if (!d_req || gd) begin
                d_addr  = 32'($urandom_range(0, 63)) << 2;
                d_we    = $urandom_range(0, 1) == 1;
                d_wdata = $urandom;
            end
            i_flush = $urandom_range(0, 7) == 0;
            rst     = $urandom_range(0, 99) == 0;
        end

        i_req = 1'b0; d_req = 1'b0; i_flush = 1'b0; rst = 1'b0;
        repeat (10) step();
        chk("queue_drained", q.size(), 32'h0);
        chk("lat1_done", done1, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : lat1
        rst1 = 1'b1; i_req1 = 1'b0; i_addr1 = 32'h10; i_flush1 = 1'b0;
        d_req1 = 1'b0; d_we1 = 1'b0; d_addr1 = '0; d_wdata1 = '0;
        m_rdata1 = 32'h00500093;
        repeat (2) @(posedge clk);
        #1 rst1 = 1'b0;
        i_req1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #3;
            chk("l1_i_gnt", i_gnt1, (k % 2) == 0);
            chk("l1_m_en", m_en1, (k % 2) == 0);
            chk("l1_m_addr", m_addr1, ((k % 2) == 0) ? 32'h10 : 32'h0);
            chk("l1_i_rvalid", i_rvalid1, (k % 2) == 1);
            chk("l1_i_rdata", i_rdata1, ((k % 2) == 1) ? 32'h00500093 : 32'h0);
            chk("l1_busy", busy1, (k % 2) == 1);
            chk("l1_d_side", {d_gnt1, d_rvalid1, m_we1}, 3'b000);
            chk("l1_zero_data", d_rdata1 | m_wdata1, 32'h0);
        end
        i_req1 = 1'b0;
        done1 = 1'b1;
    end

endmodule
